// File: rtl/vtree_stim_chk.sv
// Stimulus generator and order checker for a merge-sort tree.
// Issue path: a duty-cycled slot pointer walks the ways. Each way that reports
//   empty in its slot gets one block of records (walking-one or ascending keys).
// Capture path: tree output records are folded into an XOR checksum and
//   counted. Any key that decreases relative to the previous record raises a
//   sticky error.
module vtree_stim_chk #(
  parameter int W_LOG    = 10,
  parameter int P_LOG    = 3,
  parameter int DATW     = 64,
  parameter int KEYW     = 32,
  parameter int MODE     = 0,
  parameter int DUTY_LOG = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [(1<<W_LOG)-1:0]      EMP,
  output logic [(DATW<<P_LOG)-1:0]   DIN,
  output logic                       DINEN,
  output logic [W_LOG-1:0]           DIN_IDX,
  input  logic [DATW-1:0]            DOT,
  input  logic                       DOTEN,
  output logic [31:0]                CNT,
  output logic                       ERR,
  output logic                       OUT
);

  localparam int BW    = DATW << P_LOG;
  localparam int NLANE = 1 << P_LOG;
  // Keep at least one bit so DUTY_LOG=0 still has a legal (constant) counter.
  localparam int DW    = (DUTY_LOG > 0) ? DUTY_LOG : 1;

  // Issue-path state
  logic [DW-1:0]    duty_q, duty_d;
  logic [W_LOG-1:0] ptr_q, ptr_d;
  logic [BW-1:0]    walk_q, walk_d;
  logic [KEYW-1:0]  seq_q, seq_d;
  logic [BW-1:0]    din_q, din_d;
  logic             dinen_q, dinen_d;
  logic [W_LOG-1:0] din_idx_q, din_idx_d;

  // Capture-path state
  logic [DATW-1:0]  checksum_q, checksum_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [KEYW-1:0]  last_key_q, last_key_d;
  logic             seen_q, seen_d;
  logic             err_q, err_d;
  logic             out_q, out_d;

  logic             slot;
  logic             issue;
  logic [BW-1:0]    asc_blk;
  logic [BW-1:0]    pattern;
  logic [KEYW-1:0]  dot_key;
  logic             order_bad;

  // Ascending-key block: lane j carries key (seq<<P_LOG)+j, zero-extended.
  for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
    logic [KEYW-1:0] lane_key;
    assign lane_key = (seq_q << P_LOG) + KEYW'(gi);
    assign asc_blk[DATW*gi +: DATW] = DATW'(lane_key);
  end

  assign pattern   = (MODE == 0) ? walk_q : asc_blk;
  assign slot      = (DUTY_LOG == 0) || (duty_q == '0);
  assign issue     = slot && EMP[ptr_q];
  assign dot_key   = DOT[KEYW-1:0];
  assign order_bad = DOTEN && seen_q && (dot_key < last_key_q);

  // Next-state for the issue path: slot timing, way pointer, pattern advance.
  always_comb begin
    duty_d    = (DUTY_LOG == 0) ? '0 : duty_q + DW'(1);
    ptr_d     = slot ? ptr_q + W_LOG'(1) : ptr_q;
    dinen_d   = issue;
    din_d     = issue ? pattern : din_q;
    din_idx_d = issue ? ptr_q : din_idx_q;
    walk_d    = issue ? {walk_q[BW-2:0], walk_q[BW-1]} : walk_q;
    seq_d     = issue ? seq_q + KEYW'(1) : seq_q;
  end

  // Next-state for the capture path: checksum, saturating count, order check.
  always_comb begin
    checksum_d = checksum_q;
    cnt_d      = cnt_q;
    last_key_d = last_key_q;
    seen_d     = seen_q;
    if (DOTEN) begin
      checksum_d = checksum_q ^ DOT;
      cnt_d      = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
      last_key_d = dot_key;
      seen_d     = 1'b1;
    end
    err_d = err_q || order_bad;
    out_d = ^checksum_q;
  end

  // State registers; reset restarts both paths from a clean point.
  always_ff @(posedge CLK) begin
    if (RST) begin
      duty_q     <= '0;
      ptr_q      <= '0;
      walk_q     <= BW'(1);
      seq_q      <= '0;
      din_q      <= '0;
      dinen_q    <= 1'b0;
      din_idx_q  <= '0;
      checksum_q <= '0;
      cnt_q      <= '0;
      last_key_q <= '0;
      seen_q     <= 1'b0;
      err_q      <= 1'b0;
      out_q      <= 1'b0;
    end else begin
      duty_q     <= duty_d;
      ptr_q      <= ptr_d;
      walk_q     <= walk_d;
      seq_q      <= seq_d;
      din_q      <= din_d;
      dinen_q    <= dinen_d;
      din_idx_q  <= din_idx_d;
      checksum_q <= checksum_d;
      cnt_q      <= cnt_d;
      last_key_q <= last_key_d;
      seen_q     <= seen_d;
      err_q      <= err_d;
      out_q      <= out_d;
    end
  end

  assign DIN     = din_q;
  assign DINEN   = dinen_q;
  assign DIN_IDX = din_idx_q;
  assign CNT     = cnt_q;
  assign ERR     = err_q;
  assign OUT     = out_q;

endmodule

// File: tb/tb_vtree_stim_chk.sv
// Directed bench for vtree_stim_chk.
// dut0: walking-one pattern, one slot every 2 cycles, 4 ways.
// dut1: ascending keys, a slot every cycle.
// Expected issues are queued when EMP is driven and popped by monitors on DINEN.
module tb_vtree_stim_chk;

  localparam int BW = 256;

  typedef struct {
    logic [1:0]    idx;
    logic [BW-1:0] din;
  } issue_t;

  logic          CLK;
  logic          RST;
  logic [3:0]    emp0, emp1;
  logic [63:0]   dot;
  logic          doten;

  logic [BW-1:0] din0, din1;
  logic          dinen0, dinen1;
  logic [1:0]    idx0, idx1;
  logic [31:0]   cnt0, cnt1;
  logic          err0, err1;
  logic          out0, out1;

  int checks   = 0;
  int failures = 0;

  issue_t q0[$];
  issue_t q1[$];

  vtree_stim_chk #(
    .W_LOG(2), .P_LOG(2), .DATW(64), .KEYW(32), .MODE(0), .DUTY_LOG(1)
  ) dut0 (
    .CLK(CLK), .RST(RST), .EMP(emp0), .DIN(din0), .DINEN(dinen0),
    .DIN_IDX(idx0), .DOT(dot), .DOTEN(doten), .CNT(cnt0), .ERR(err0), .OUT(out0)
  );

  vtree_stim_chk #(
    .W_LOG(2), .P_LOG(2), .DATW(64), .KEYW(32), .MODE(1), .DUTY_LOG(0)
  ) dut1 (
    .CLK(CLK), .RST(RST), .EMP(emp1), .DIN(din1), .DINEN(dinen1),
    .DIN_IDX(idx1), .DOT(dot), .DOTEN(doten), .CNT(cnt1), .ERR(err1), .OUT(out1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [BW-1:0] asc_block(input int s);
    logic [BW-1:0] b;
    b = '0;
    for (int j = 0; j < 4; j++) b[64*j +: 64] = 64'(s * 4 + j);
    return b;
  endfunction

  task automatic push0(input logic [1:0] idx, input logic [BW-1:0] din);
    issue_t e;
    e.idx = idx;
    e.din = din;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [1:0] idx, input logic [BW-1:0] din);
    issue_t e;
    e.idx = idx;
    e.din = din;
    q1.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_din"},   din0,   '0);
    check({tag, "_dinen"}, dinen0, '0);
    check({tag, "_idx"},   idx0,   '0);
    check({tag, "_cnt"},   cnt0,   '0);
    check({tag, "_err"},   err0,   '0);
    check({tag, "_out"},   out0,   '0);
  endtask

  // dut0 scoreboard: every DINEN pulse must match the oldest queued issue.
  always @(negedge CLK) begin
    if (dinen0 === 1'b1) begin
      if (q0.size() == 0) begin
        check("dut0_unexpected_issue", BW'(q0.size()), BW'(1));
      end else begin
        issue_t e;
        e = q0.pop_front();
        $display("dut0 issue idx=%0d din=%0h", idx0, din0);
        check("dut0_issue_idx", idx0, e.idx);
        check("dut0_issue_din", din0, e.din);
      end
    end
  end

  // dut1 scoreboard.
  always @(negedge CLK) begin
    if (dinen1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_issue", BW'(q1.size()), BW'(1));
      end else begin
        issue_t e;
        e = q1.pop_front();
        $display("dut1 issue idx=%0d din=%0h", idx1, din1);
        check("dut1_issue_idx", idx1, e.idx);
        check("dut1_issue_din", din1, e.din);
      end
    end
  end

  initial begin
    logic [31:0] keys_b [4];
    logic        dinen_b [9];
    keys_b  = '{32'd5, 32'd5, 32'd9, 32'd3};
    dinen_b = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    RST = 1'b1; emp0 = '0; emp1 = '0; dot = '0; doten = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    check("reset_dut1_dinen", dinen1, '0);
    check("reset_dut1_din",   din1,   '0);

    // Phase A: all ways empty on dut0, ascending keys on dut1, small capture.
    RST  = 1'b0;
    emp0 = 4'b1111;
    emp1 = 4'b1111;
    for (int i = 0; i < 5; i++) push0(2'(i % 4), BW'(1) << i);
    for (int i = 0; i < 3; i++) push1(2'(i), asc_block(i));
    dot = 64'h1; doten = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      $display("phaseA cycle=%0d dinen0=%0b idx0=%0d cnt0=%0d out0=%0b", k, dinen0, idx0, cnt0, out0);
      check("A_dinen_duty", dinen0, BW'(k % 2));
      if (k == 1) begin
        check("A_cnt1", cnt0, 32'd1);
        check("A_out_before_update", out0, 1'b0);
        dot = 64'h3;
      end else if (k == 2) begin
        check("A_cnt2", cnt0, 32'd2);
        check("A_out_after_0x1", out0, 1'b1);
        doten = 1'b0; dot = '0;
      end else if (k == 3) begin
        check("A_out_after_0x2", out0, 1'b1);
        check("A_cnt_hold", cnt0, 32'd2);
        check("A_err_ascending", err0, 1'b0);
        emp1 = 4'b0000;
      end
    end

    // Slot with EMP low, then an EMP pulse confined to a non-slot cycle.
    emp0 = 4'b0000;
    step();
    check("A_noemp_dinen", dinen0, 1'b0);
    check("A_hold_din", din0, BW'(16));
    check("A_hold_idx", idx0, 2'd0);
    emp0 = 4'b1111;
    step();
    check("A_nonslot_dinen", dinen0, 1'b0);
    emp0 = 4'b0000;
    step();
    check("A_nonslot_emp_ignored", dinen0, 1'b0);
    check("A_hold_din2", din0, BW'(16));

    // Phase B: reset, sparse EMP, and out-of-order keys in parallel.
    RST = 1'b1;
    step();
    check_reset_outputs("resetB");
    RST  = 1'b0;
    emp0 = 4'b0101;
    push0(2'd0, BW'(1));
    push0(2'd2, BW'(2));
    dot = 64'(keys_b[0]); doten = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      $display("phaseB cycle=%0d dinen0=%0b err0=%0b cnt0=%0d", k, dinen0, err0, cnt0);
      check("B_dinen", dinen0, BW'(dinen_b[k]));
      check("B_err", err0, BW'(k >= 4));
      if (k < 4) begin
        dot = 64'(keys_b[k]);
      end else if (k == 4) begin
        doten = 1'b0; dot = '0;
        check("B_cnt4", cnt0, 32'd4);
      end
    end
    check("B_cnt_hold", cnt0, 32'd4);

    // Phase C: reset while DINEN=1 and ERR=1.
    emp0 = 4'b1111;
    push0(2'd0, BW'(4));
    step();
    check("C_dinen_before_rst", dinen0, 1'b1);
    check("C_err_before_rst", err0, 1'b1);
    RST = 1'b1;
    step();
    check_reset_outputs("resetC");
    step();
    check("C_rst_slot_abort", dinen0, 1'b0);
    check("C_rst_din_zero", din0, '0);
    RST = 1'b0;
    push0(2'd0, BW'(1));
    step();
    $display("phaseC restart dinen0=%0b idx0=%0d din0=%0h", dinen0, idx0, din0);
    check("C_restart_dinen", dinen0, 1'b1);
    check("C_restart_idx", idx0, 2'd0);
    check("C_restart_din", din0, BW'(1));
    emp0 = 4'b0000;
    step();
    step();

    check("q0_drained", BW'(q0.size()), BW'(0));
    check("q1_drained", BW'(q1.size()), BW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
